mem_bus_arbiter: RTL and testbench

//  - Shares one memory-bus slave port between 3 masters: M0 instruction fetch, M1 load/store, M2 spare (debug/DMA).
//  - Sits between the core's master ports and the address decoder. Serialises one transaction at a time.
//  - Generates per-master stall and read-valid signals. Aborts hung slave accesses with a timeout.

---
 rtl/mem_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory-bus slave port between three masters:
//   M0 instruction fetch, M1 load/store, M2 spare (debug/DMA).
// One transaction is in flight at a time. The FSM walks IDLE -> BUSY -> RESP.
// A slave that never acknowledges is aborted after TIMEOUT BUSY cycles; the
// aborted master gets a zero read response and bus_err pulses.
//
// Handshake: a master raises mN_en_r and/or mN_en_w and holds address, byte
// enables and data stable while mN_stall is high. The single cycle in which
// mN_stall is low (RESP for that master) completes the request; mN_r_valid
// pulses in the same cycle for reads. On the slave side s_req stays high for
// the whole BUSY phase, s_* payload is stable throughout, and the first cycle
// with s_ack high ends the access (s_rdata sampled in that cycle).
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority M1 > M0 > M2
//                      undefined -> round-robin starting after last grant
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mN_en_r / mN_en_w         read / write request per master (N = 0..2)
//   mN_addr, mN_sel, mN_wdata request payload per master
//   mN_stall                  request pending, hold inputs
//   mN_rdata, mN_r_valid      read data (holds last value) and 1-cycle valid
//   s_req, s_we, s_addr,
//   s_sel, s_wdata            registered slave request
//   s_ack, s_rdata            slave completion and read data
//   bus_err, err_id           timeout abort pulse and id of aborted master
//   dbg_state                 current FSM state (0 IDLE, 1 BUSY, 2 RESP)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_en_r,
    input  logic              m0_en_w,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [7:0]        m0_sel,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_stall,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_r_valid,

    input  logic              m1_en_r,
    input  logic              m1_en_w,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [7:0]        m1_sel,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_stall,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_r_valid,

    input  logic              m2_en_r,
    input  logic              m2_en_w,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [7:0]        m2_sel,
    input  logic [DATA_W-1:0] m2_wdata,
    output logic              m2_stall,
    output logic [DATA_W-1:0] m2_rdata,
    output logic              m2_r_valid,

    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_sel,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ack,
    input  logic [DATA_W-1:0] s_rdata,

    output logic              bus_err,
    output logic [1:0]        err_id,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_n;

    // Per-master views gathered into vectors so selection can be indexed.
    logic [2:0]        req;
    logic [2:0]        en_w;
    logic [ADDR_W-1:0] addr_a  [3];
    logic [7:0]        sel_a   [3];
    logic [DATA_W-1:0] wdata_a [3];
    logic [DATA_W-1:0] rdata_q [3];

    logic [1:0] g;          // master owning the current transaction
    logic [1:0] pick;       // arbitration winner while IDLE
    logic [7:0] cnt;        // BUSY cycles elapsed without s_ack
    logic       timeout_hit;
    logic       done;

    assign req  = {m2_en_r | m2_en_w, m1_en_r | m1_en_w, m0_en_r | m0_en_w};
    assign en_w = {m2_en_w, m1_en_w, m0_en_w};

    assign addr_a[0]  = m0_addr;
    assign addr_a[1]  = m1_addr;
    assign addr_a[2]  = m2_addr;
    assign sel_a[0]   = m0_sel;
    assign sel_a[1]   = m1_sel;
    assign sel_a[2]   = m2_sel;
    assign wdata_a[0] = m0_wdata;
    assign wdata_a[1] = m1_wdata;
    assign wdata_a[2] = m2_wdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
    // Loads/stores first so fetch can never starve them, spare port last.
    always_comb begin
        pick = 2'd2;
        if (req[1])
            pick = 2'd1;
        else if (req[0])
            pick = 2'd0;
    end
`else
    logic [1:0] last_grant;
    logic [1:0] rr_start;
    logic [2:0] cand;

    // Scan from lowest to highest priority so the last hit is the winner;
    // highest priority is the master right after the previous grant.
    always_comb begin
        pick     = 2'd0;
        cand     = 3'd0;
        rr_start = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, rr_start} + 3'(k);
            if (cand >= 3'd3)
                cand = cand - 3'd3;
            if (req[cand[1:0]])
                pick = cand[1:0];
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    // An ack in the final counted cycle wins over the abort.
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1)) && !s_ack;
    assign done        = s_ack || timeout_hit;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|req) state_n = BUSY;
            BUSY:    if (done) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            g       <= 2'd0;
            cnt     <= 8'd0;
            s_req   <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_sel   <= 8'h00;
            s_wdata <= '0;
            bus_err <= 1'b0;
            err_id  <= 2'd0;
            for (int n = 0; n < 3; n++)
                rdata_q[n] <= '0;
        end else begin
            state   <= state_n;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        // Write wins when a master raises both; its read is
                        // picked up on a later grant.
                        g       <= pick;
                        s_req   <= 1'b1;
                        s_we    <= en_w[pick];
                        s_addr  <= addr_a[pick];
                        s_sel   <= en_w[pick] ? sel_a[pick] : 8'hFF;
                        s_wdata <= wdata_a[pick];
                        cnt     <= 8'd0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        s_req <= 1'b0;
                        cnt   <= 8'd0;
                        // Response data is loaded here so it is already
                        // visible during RESP alongside r_valid.
                        if (!s_we) begin
                            for (int n = 0; n < 3; n++)
                                if (g == 2'(n))
                                    rdata_q[n] <= s_ack ? s_rdata : '0;
                        end
                        if (timeout_hit) begin
                            bus_err <= 1'b1;
                            err_id  <= g;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Reset to 2 so that M0 is searched first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 2'd2;
        else if (state == IDLE && |req)
            last_grant <= pick;
    end
`endif

    // ------------------------------------------------------------------
    // Master-side outputs
    // ------------------------------------------------------------------
    logic in_resp;
    assign in_resp = (state == RESP);

    assign m0_stall   = req[0] && !(in_resp && g == 2'd0);
    assign m1_stall   = req[1] && !(in_resp && g == 2'd1);
    assign m2_stall   = req[2] && !(in_resp && g == 2'd2);

    assign m0_r_valid = in_resp && g == 2'd0 && !s_we;
    assign m1_r_valid = in_resp && g == 2'd1 && !s_we;
    assign m2_r_valid = in_resp && g == 2'd2 && !s_we;

    assign m0_rdata   = rdata_q[0];
    assign m1_rdata   = rdata_q[1];
    assign m2_rdata   = rdata_q[2];

    assign dbg_state  = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_en_r = 0, m0_en_w = 0, m1_en_r = 0, m1_en_w = 0, m2_en_r = 0, m2_en_w = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0, m2_addr = '0;
    logic [7:0]    m0_sel = '0, m1_sel = '0, m2_sel = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, m2_wdata = '0;
    logic          m0_stall, m1_stall, m2_stall;
    logic [DW-1:0] m0_rdata, m1_rdata, m2_rdata;
    logic          m0_r_valid, m1_r_valid, m2_r_valid;
    logic          s_req, s_we;
    logic [AW-1:0] s_addr;
    logic [7:0]    s_sel;
    logic [DW-1:0] s_wdata;
    logic          s_ack = 1'b0;
    logic [DW-1:0] s_rdata = '0;
    logic          bus_err;
    logic [1:0]    err_id;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_en_r(m0_en_r), .m0_en_w(m0_en_w), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
        .m0_stall(m0_stall), .m0_rdata(m0_rdata), .m0_r_valid(m0_r_valid),
        .m1_en_r(m1_en_r), .m1_en_w(m1_en_w), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_stall(m1_stall), .m1_rdata(m1_rdata), .m1_r_valid(m1_r_valid),
        .m2_en_r(m2_en_r), .m2_en_w(m2_en_w), .m2_addr(m2_addr), .m2_sel(m2_sel), .m2_wdata(m2_wdata),
        .m2_stall(m2_stall), .m2_rdata(m2_rdata), .m2_r_valid(m2_r_valid),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .bus_err(bus_err), .err_id(err_id), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic drop_all();
        m0_en_r = 0; m0_en_w = 0; m1_en_r = 0; m1_en_w = 0; m2_en_r = 0; m2_en_w = 0;
        s_ack = 0; s_rdata = '0;
    endtask

    task automatic apply_reset();
        drop_all();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        checks++; if ({s_req, s_we, bus_err} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b want 000", {s_req, s_we, bus_err}); end
        checks++; if (s_addr !== '0 || s_wdata !== '0 || s_sel !== 8'h00) begin errors++; $display("FAIL rst_payload: addr %h wdata %h sel %h want 0", s_addr, s_wdata, s_sel); end
        checks++; if (err_id !== 2'd0) begin errors++; $display("FAIL rst_err_id: got %0d want 0", err_id); end
        checks++; if (m0_rdata !== '0 || m1_rdata !== '0 || m2_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h %h %h want 0", m0_rdata, m1_rdata, m2_rdata); end
        checks++; if ({m0_stall, m1_stall, m2_stall, m0_r_valid, m1_r_valid, m2_r_valid} !== 6'b0) begin errors++; $display("FAIL rst_flags: got %b want 000000", {m0_stall, m1_stall, m2_stall, m0_r_valid, m1_r_valid, m2_r_valid}); end
    endtask

    task automatic test_single_read();
        m0_en_r = 1; m0_addr = 64'h80;
        #1;
        checks++; if (m0_stall !== 1'b1 || m0_r_valid !== 1'b0) begin errors++; $display("FAIL rd_c0: stall %b r_valid %b want 1 0", m0_stall, m0_r_valid); end
        @(negedge clk);
        checks++; if (s_req !== 1'b1 || s_we !== 1'b0 || s_addr !== 64'h80 || s_sel !== 8'hFF) begin errors++; $display("FAIL rd_c1_bus: req %b we %b addr %h sel %h want 1 0 80 ff", s_req, s_we, s_addr, s_sel); end
        checks++; if (m0_stall !== 1'b1) begin errors++; $display("FAIL rd_c1_stall: got %b want 1", m0_stall); end
        s_ack = 1; s_rdata = 64'hDEAD_BEEF;
        @(negedge clk);
        s_ack = 0;
        checks++; if (m0_stall !== 1'b0 || m0_r_valid !== 1'b1 || m0_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL rd_c2: stall %b r_valid %b rdata %h want 0 1 deadbeef", m0_stall, m0_r_valid, m0_rdata); end
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rd_c2_req: got %b want 0", s_req); end
        m0_en_r = 0;
        @(negedge clk);
        checks++; if (m0_r_valid !== 1'b0 || m0_stall !== 1'b0 || m0_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL rd_c3: r_valid %b stall %b rdata %h want 0 0 deadbeef", m0_r_valid, m0_stall, m0_rdata); end
    endtask

    task automatic test_write();
        m1_en_w = 1; m1_addr = 64'h1000; m1_sel = 8'h0F; m1_wdata = 64'h1234;
        #1;
        checks++; if (m1_stall !== 1'b1) begin errors++; $display("FAIL wr_c0_stall: got %b want 1", m1_stall); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (s_req !== 1'b1 || s_we !== 1'b1 || s_sel !== 8'h0F || s_addr !== 64'h1000 || s_wdata !== 64'h1234) begin
                errors++; $display("FAIL wr_busy%0d: req %b we %b sel %h addr %h wdata %h", i, s_req, s_we, s_sel, s_addr, s_wdata);
            end
            checks++; if (m1_stall !== 1'b1 || m1_r_valid !== 1'b0) begin errors++; $display("FAIL wr_busy%0d_m1: stall %b r_valid %b want 1 0", i, m1_stall, m1_r_valid); end
            if (i == 2) begin s_ack = 1; s_rdata = 64'hBAD; end
        end
        @(negedge clk);
        s_ack = 0;
        checks++; if (m1_stall !== 1'b0 || m1_r_valid !== 1'b0 || s_req !== 1'b0) begin errors++; $display("FAIL wr_resp: stall %b r_valid %b req %b want 0 0 0", m1_stall, m1_r_valid, s_req); end
        checks++; if (m1_rdata !== '0) begin errors++; $display("FAIL wr_rdata: got %h want 0", m1_rdata); end
        m1_en_w = 0;
        @(negedge clk);
        checks++; if (dbg_state !== 2'd0 || s_sel !== 8'h0F || s_req !== 1'b0) begin errors++; $display("FAIL wr_idle: state %0d sel %h req %b want 0 0f 0", dbg_state, s_sel, s_req); end
    endtask

    task automatic test_back_to_back();
        m0_en_r = 1; m0_en_w = 1; m0_addr = 64'h600; m0_sel = 8'h3C; m0_wdata = 64'hCAFE;
        @(negedge clk);
        checks++; if (s_we !== 1'b1 || s_sel !== 8'h3C || s_wdata !== 64'hCAFE) begin errors++; $display("FAIL b2b_wr: we %b sel %h wdata %h want 1 3c cafe", s_we, s_sel, s_wdata); end
        s_ack = 1; s_rdata = 64'h77;
        @(negedge clk);
        s_ack = 0;
        checks++; if (m0_stall !== 1'b0 || m0_r_valid !== 1'b0 || m0_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL b2b_wr_resp: stall %b r_valid %b rdata %h", m0_stall, m0_r_valid, m0_rdata); end
        m0_en_w = 0;
        @(negedge clk);
        checks++; if (m0_stall !== 1'b1 || s_req !== 1'b0) begin errors++; $display("FAIL b2b_idle: stall %b req %b want 1 0", m0_stall, s_req); end
        @(negedge clk);
        checks++; if (s_req !== 1'b1 || s_we !== 1'b0 || s_sel !== 8'hFF || s_addr !== 64'h600) begin errors++; $display("FAIL b2b_rd: req %b we %b sel %h addr %h", s_req, s_we, s_sel, s_addr); end
        s_ack = 1; s_rdata = 64'h88;
        @(negedge clk);
        s_ack = 0;
        checks++; if (m0_r_valid !== 1'b1 || m0_rdata !== 64'h88) begin errors++; $display("FAIL b2b_rd_resp: r_valid %b rdata %h want 1 88", m0_r_valid, m0_rdata); end
        m0_en_r = 0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [1:0]    order [3];
        logic [2:0]    exp_vec;
        logic [DW-1:0] got;
        int            waited;
`ifdef ARB_FIXED_PRIO_EN
        order = '{2'd1, 2'd0, 2'd2};
`else
        order = '{2'd0, 2'd1, 2'd2};
`endif
        apply_reset();
        m0_en_r = 1; m0_addr = 64'h100;
        m1_en_r = 1; m1_addr = 64'h200;
        m2_en_r = 1; m2_addr = 64'h300;
        for (int i = 0; i < 3; i++) begin
            waited = 0;
            do begin @(negedge clk); waited++; end while (!s_req && waited < 6);
            checks++; if (!s_req || waited != ((i == 0) ? 1 : 2)) begin errors++; $display("FAIL cont%0d_latency: req %b waited %0d", i, s_req, waited); end
            checks++; if (s_addr !== 64'h100 * (order[i] + 1)) begin errors++; $display("FAIL cont%0d_grant: addr %h want master %0d", i, s_addr, order[i]); end
            s_ack = 1; s_rdata = 64'hA000 + 64'(order[i]);
            @(negedge clk);
            s_ack = 0;
            exp_vec = 3'b001 << order[i];
            checks++; if ({m2_r_valid, m1_r_valid, m0_r_valid} !== exp_vec) begin errors++; $display("FAIL cont%0d_valid: got %b want %b", i, {m2_r_valid, m1_r_valid, m0_r_valid}, exp_vec); end
            case (order[i])
                2'd0:    begin got = m0_rdata; m0_en_r = 0; end
                2'd1:    begin got = m1_rdata; m1_en_r = 0; end
                default: begin got = m2_rdata; m2_en_r = 0; end
            endcase
            checks++; if (got !== 64'hA000 + 64'(order[i])) begin errors++; $display("FAIL cont%0d_rdata: got %h want %h", i, got, 64'hA000 + 64'(order[i])); end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int count = 0;
        m2_en_r = 1; m2_addr = 64'h400;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_req) count++;
            else if (count > 0) break;
        end
        checks++; if (count != 16) begin errors++; $display("FAIL to_req_len: got %0d want 16", count); end
        checks++; if (bus_err !== 1'b1 || err_id !== 2'd2) begin errors++; $display("FAIL to_err: bus_err %b err_id %0d want 1 2", bus_err, err_id); end
        checks++; if (m2_r_valid !== 1'b1 || m2_rdata !== '0 || m2_stall !== 1'b0) begin errors++; $display("FAIL to_resp: r_valid %b rdata %h stall %b want 1 0 0", m2_r_valid, m2_rdata, m2_stall); end
        m2_en_r = 0;
        @(negedge clk);
        checks++; if (bus_err !== 1'b0 || m2_r_valid !== 1'b0) begin errors++; $display("FAIL to_pulse: bus_err %b r_valid %b want 0 0", bus_err, m2_r_valid); end
    endtask

    task automatic test_ack_timeout_collide();
        int count = 0;
        m0_en_r = 1; m0_addr = 64'h500;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_req) begin
                count++;
                if (count == 16) begin s_ack = 1; s_rdata = 64'h55; end
            end else if (count > 0) break;
        end
        s_ack = 0;
        checks++; if (count != 16) begin errors++; $display("FAIL col_len: got %0d want 16", count); end
        checks++; if (bus_err !== 1'b0 || err_id !== 2'd2) begin errors++; $display("FAIL col_err: bus_err %b err_id %0d want 0 2", bus_err, err_id); end
        checks++; if (m0_r_valid !== 1'b1 || m0_rdata !== 64'h55) begin errors++; $display("FAIL col_rdata: r_valid %b rdata %h want 1 55", m0_r_valid, m0_rdata); end
        m0_en_r = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        m1_en_r = 1; m1_addr = 64'h700;
        @(negedge clk);
        checks++; if (s_req !== 1'b1 || dbg_state !== 2'd1) begin errors++; $display("FAIL rmid_busy: req %b state %0d want 1 1", s_req, dbg_state); end
        rst = 1; m1_en_r = 0;
        #1;
        checks++; if (s_req !== 1'b0 || dbg_state !== 2'd0 || err_id !== 2'd0 || s_addr !== '0 || s_sel !== 8'h00) begin errors++; $display("FAIL rmid_async: req %b state %0d err_id %0d addr %h sel %h", s_req, dbg_state, err_id, s_addr, s_sel); end
        checks++; if (m0_rdata !== '0 || m1_rdata !== '0 || m2_rdata !== '0 || {m0_r_valid, m1_r_valid, m2_r_valid} !== 3'b000) begin errors++; $display("FAIL rmid_outs: rdata %h %h %h r_valid %b", m0_rdata, m1_rdata, m2_rdata, {m0_r_valid, m1_r_valid, m2_r_valid}); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        m0_en_r = 1; m0_addr = 64'h800;
        @(negedge clk);
        checks++; if (s_req !== 1'b1 || s_addr !== 64'h800) begin errors++; $display("FAIL rmid_fresh_req: req %b addr %h want 1 800", s_req, s_addr); end
        s_ack = 1; s_rdata = 64'h99;
        @(negedge clk);
        s_ack = 0;
        checks++; if (m0_r_valid !== 1'b1 || m0_rdata !== 64'h99 || m1_r_valid !== 1'b0) begin errors++; $display("FAIL rmid_fresh_resp: r_valid %b rdata %h m1_r_valid %b", m0_r_valid, m0_rdata, m1_r_valid); end
        m0_en_r = 0;
        @(negedge clk);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_back_to_back();
        test_contention();
        test_timeout();
        test_ack_timeout_collide();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
